// File: rtl/bsg_ral_sdr_test_pkg.sv
// Shared types and constants for the SDR link test responder.
// Ports: none (package). Holds the FSM state enum, counter widths and
// the ready/and link width helper used to size link_sif ports.
package bsg_ral_sdr_test_pkg;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eRun   = 2'd1,
        eDrain = 2'd2
    } state_e;

    localparam int cnt_width_lp = 32;
    localparam int err_width_lp = 16;

    // ready/and link layout, MSB first: {v, data[flit_width-1:0], ready_and_rev}
    function automatic int link_sif_width(input int flit_width);
        return flit_width + 2;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small registered FIFO with ready/valid on the write side and valid/yumi on the read side.
// Ports: clk_i, reset_n_i (async active-low), v_i/ready_o/data_i enqueue, v_o/data_o/yumi_i dequeue.
// ready_o depends only on stored occupancy; a same-cycle dequeue never frees a slot for a full FIFO.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, wptr_q;
    logic [cnt_w_lp-1:0] count_q;
    logic                enq, deq;

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wptr_q <= (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_q <= (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bsg_ral_sdr_pattern_gen.sv
// Expected-flit generator: channel c of flit n carries (n + c) mod 2^channel_width_p.
// Ports: clk_i, reset_n_i (async active-low), yumi_i advances to the next flit,
// o is the expected flit for the current index (combinational from the index register).
module bsg_ral_sdr_pattern_gen #(
    parameter int channel_width_p = 8,
    parameter int num_channels_p  = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      yumi_i,
    output logic [channel_width_p*num_channels_p-1:0] o
);

    // Only the low channel_width_p bits of the index matter for the pattern.
    logic [channel_width_p-1:0] idx_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q <= '0;
        end else if (yumi_i) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    always_comb begin
        o = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            o[c*channel_width_p +: channel_width_p] = idx_q + channel_width_p'(c);
        end
    end

endmodule

// File: rtl/bsg_ral_link_sdr_echo_node.sv
// Responder end of the SDR ready/and link test: checks each accepted flit against
// a locally generated pattern, buffers it and echoes it back unchanged and in order.
// Ports: clk_i, reset_n_i (async active-low), en_i run enable, link_sif_i/link_sif_o
// ready/and link {v, data, ready_and_rev}; busy_o, error_o, err_count_o,
// first_err_idx_o, received_o, echoed_o status.
module bsg_ral_link_sdr_echo_node
    import bsg_ral_sdr_test_pkg::*;
#(
    parameter int flit_width_p    = 32,
    parameter int channel_width_p = 8,
    parameter int els_p           = 4,
    localparam int num_channels_lp   = flit_width_p / channel_width_p,
    localparam int link_sif_width_lp = link_sif_width(flit_width_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    output logic                         busy_o,
    output logic                         error_o,
    output logic [err_width_lp-1:0]      err_count_o,
    output logic [cnt_width_lp-1:0]      first_err_idx_o,
    output logic [cnt_width_lp-1:0]      received_o,
    output logic [cnt_width_lp-1:0]      echoed_o
);

    typedef struct packed {
        logic                    v;
        logic [flit_width_p-1:0] data;
        logic                    ready_and_rev;
    } link_sif_s;

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    state_e state_q, state_n;

    logic                    fifo_ready, fifo_v;
    logic [flit_width_p-1:0] fifo_data, expected;
    logic                    ready, accept, deq, mismatch;

    logic                    error_q;
    logic [err_width_lp-1:0] err_count_q;
    logic [cnt_width_lp-1:0] first_err_q, received_q, echoed_q;

    // Accept depends on registered state plus en_i only; nothing from link_sif_i.
    assign ready    = (state_q == eRun) & en_i & fifo_ready;
    assign accept   = link_in.v & ready;
    assign deq      = fifo_v & link_in.ready_and_rev;
    assign mismatch = accept & (link_in.data != expected);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIdle;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            eIdle:   if (en_i)    state_n = eRun;
            eRun:    if (!en_i)   state_n = eDrain;
            eDrain:  if (!fifo_v) state_n = eIdle;
            default: state_n = eIdle;
        endcase
    end

    bsg_ral_sdr_pattern_gen #(
        .channel_width_p(channel_width_p),
        .num_channels_p (num_channels_lp)
    ) pattern (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .yumi_i   (accept),
        .o        (expected)
    );

    bsg_fifo_1r1w_small #(
        .width_p(flit_width_p),
        .els_p  (els_p)
    ) echo_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (accept),
        .ready_o  (fifo_ready),
        .data_i   (link_in.data),
        .v_o      (fifo_v),
        .data_o   (fifo_data),
        .yumi_i   (deq)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_q     <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            received_q  <= '0;
            echoed_q    <= '0;
        end else begin
            if (accept) begin
                received_q <= received_q + 1'b1;
            end
            if (deq) begin
                echoed_q <= echoed_q + 1'b1;
            end
            if (mismatch) begin
                error_q <= 1'b1;
                // Index is only captured for the very first mismatch since reset.
                if (err_count_q == '0) begin
                    first_err_q <= received_q;
                end
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        link_out               = '0;
        link_out.v             = fifo_v;
        link_out.data          = fifo_data;
        link_out.ready_and_rev = ready;
    end

    assign busy_o          = (state_q != eIdle);
    assign error_o         = error_q;
    assign err_count_o     = err_count_q;
    assign first_err_idx_o = first_err_q;
    assign received_o      = received_q;
    assign echoed_o        = echoed_q;

endmodule

// File: tb/tb_bsg_ral_link_sdr_echo_node.sv
module tb_bsg_ral_link_sdr_echo_node;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        m_v = 1'b0;
    logic [31:0] m_dat = '0;
    logic        h_rdy = 1'b0;
    logic [33:0] link_in, link_out;
    logic        busy, error;
    logic [15:0] err_count;
    logic [31:0] first_err, received, echoed;

    wire        o_v   = link_out[33];
    wire [31:0] o_dat = link_out[32:1];
    wire        o_rdy = link_out[0];

    assign link_in = {m_v, m_dat, h_rdy};

    int          checks = 0;
    int          errors = 0;
    int          m_idx = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_echo = -1;
    logic [63:0] bad_mask = '0;
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    bsg_ral_link_sdr_echo_node #(
        .flit_width_p   (32),
        .channel_width_p(8),
        .els_p          (4)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .en_i           (en),
        .link_sif_i     (link_in),
        .link_sif_o     (link_out),
        .busy_o         (busy),
        .error_o        (error),
        .err_count_o    (err_count),
        .first_err_idx_o(first_err),
        .received_o     (received),
        .echoed_o       (echoed)
    );

    function automatic logic [31:0] pat(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step();
        bit acc;
        m_dat = pat(m_idx) ^ ((m_idx < 64 && bad_mask[m_idx]) ? 32'h1 : 32'h0);
        #1;
        acc = m_v && o_rdy;
        if (o_v && h_rdy) begin
            got_q.push_back(o_dat);
            if (first_echo < 0) first_echo = cyc;
        end
        if (acc && first_acc < 0) first_acc = cyc;
        @(posedge clk);
        if (acc) begin
            m_idx++;
            n_acc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Offer flits until index 'count' is accepted, then wait for the FIFO to empty.
    task automatic run_stream(input int count, input int bound, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < bound; i++) begin
            m_v = (m_idx < count);
            if (m_idx >= count && !o_v) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
        m_v = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        m_v = 1'b0;
        h_rdy = 1'b0;
        m_idx = 0;
        n_acc = 0;
        first_acc = -1;
        first_echo = -1;
        bad_mask = '0;
        got_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({o_v, o_rdy, busy, error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got v=%b rdy=%b busy=%b err=%b want all 0", o_v, o_rdy, busy, error);
        end
        checks++;
        if (received !== 0 || echoed !== 0 || err_count !== 0 || first_err !== 0) begin
            errors++;
            $display("FAIL reset_counters got rx=%0d ex=%0d ec=%0d fe=%0d want 0", received, echoed, err_count, first_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit to;
        int bad;
        en = 1'b1;
        h_rdy = 1'b1;
        run_stream(8, 60, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL b2b_timeout got timeout want completion");
        end
        checks++;
        if (first_echo !== first_acc + 1) begin
            errors++;
            $display("FAIL b2b_latency got first echo cycle %0d want %0d", first_echo, first_acc + 1);
        end
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL b2b_count got %0d echoes want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== pat(i)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], pat(i));
                end
            end
        end
        checks++;
        if (received !== 8 || echoed !== 8 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_status got rx=%0d ex=%0d err=%b want 8 8 0", received, echoed, error);
        end
        bad = 0;
        checks++;
        if (got_q.size() > 0 && got_q[0] !== 32'h03020100) begin
            errors++;
            $display("FAIL b2b_first got %h want 03020100", got_q[0]);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int acc0;
        got_q.delete();
        h_rdy = 1'b0;
        acc0 = n_acc;
        m_v = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (n_acc - acc0 !== 4) begin
            errors++;
            $display("FAIL bp_accepted got %0d want 4", n_acc - acc0);
        end
        #1;
        checks++;
        if (o_rdy !== 1'b0 || received !== 12 || echoed !== 8) begin
            errors++;
            $display("FAIL bp_full got rdy=%b rx=%0d ex=%0d want 0 12 8", o_rdy, received, echoed);
        end
        h_rdy = 1'b1;
        run_stream(20, 80, to);
        checks++;
        if (to || got_q.size() !== 12) begin
            errors++;
            $display("FAIL bp_resume got to=%b echoes=%0d want 0 12", to, got_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_q[i] !== pat(8 + i)) begin
                    errors++;
                    $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], pat(8 + i));
                end
            end
        end
        checks++;
        if (received !== 20 || echoed !== 20) begin
            errors++;
            $display("FAIL bp_counts got rx=%0d ex=%0d want 20 20", received, echoed);
        end
    endtask

    task automatic test_error();
        bit err_before;
        bit seen;
        apply_reset();
        en = 1'b1;
        h_rdy = 1'b1;
        bad_mask[5] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m_v = (m_idx < 10);
            if (m_idx >= 10 && !o_v) break;
            err_before = error;
            if (m_idx == 5) begin
                step();
                if (m_idx == 6) begin
                    seen = 1'b1;
                    checks++;
                    if (err_before !== 1'b0 || error !== 1'b1) begin
                        errors++;
                        $display("FAIL err_timing got before=%b after=%b want 0 1", err_before, error);
                    end
                end
            end else begin
                step();
            end
        end
        m_v = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL err_seen got no accept of flit 5 want accept");
        end
        checks++;
        if (err_count !== 16'd1 || first_err !== 32'd5 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_status got ec=%0d fe=%0d err=%b want 1 5 1", err_count, first_err, error);
        end
        checks++;
        if (got_q.size() !== 10 || got_q[5] !== (pat(5) ^ 32'h1) || got_q[6] !== pat(6)) begin
            errors++;
            $display("FAIL err_echo got n=%0d d5=%h want 10 %h", got_q.size(), got_q[5], pat(5) ^ 32'h1);
        end
    endtask

    task automatic test_drain();
        int i;
        apply_reset();
        en = 1'b1;
        h_rdy = 1'b0;
        for (i = 0; i < 20 && n_acc < 3; i++) begin
            m_v = (m_idx < 3);
            step();
        end
        m_v = 1'b0;
        en = 1'b0;
        #1;
        checks++;
        if (o_rdy !== 1'b0 || busy !== 1'b1 || n_acc !== 3) begin
            errors++;
            $display("FAIL drain_enter got rdy=%b busy=%b acc=%0d want 0 1 3", o_rdy, busy, n_acc);
        end
        step();
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (o_rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_pulse[%0d] got rdy=%b busy=%b want 0 1", k, o_rdy, busy);
            end
            step();
        end
        en = 1'b0;
        h_rdy = 1'b1;
        for (i = 0; i < 20 && busy; i++) step();
        checks++;
        if (busy !== 1'b0 || got_q.size() !== 3 || echoed !== 3) begin
            errors++;
            $display("FAIL drain_done got busy=%b echoes=%0d ex=%0d want 0 3 3", busy, got_q.size(), echoed);
        end
        checks++;
        if (got_q.size() == 3 && got_q[2] !== pat(2)) begin
            errors++;
            $display("FAIL drain_data got %h want %h", got_q[2], pat(2));
        end
    endtask

    task automatic test_async_reset();
        bit to;
        apply_reset();
        en = 1'b1;
        h_rdy = 1'b0;
        bad_mask[0] = 1'b1;
        for (int i = 0; i < 20 && n_acc < 2; i++) begin
            m_v = (m_idx < 2);
            step();
        end
        m_v = 1'b0;
        checks++;
        if (o_v !== 1'b1 || error !== 1'b1 || received !== 2) begin
            errors++;
            $display("FAIL ar_setup got v=%b err=%b rx=%0d want 1 1 2", o_v, error, received);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_v !== 1'b0 || o_rdy !== 1'b0 || error !== 1'b0 || received !== 0 || err_count !== 0) begin
            errors++;
            $display("FAIL ar_async got v=%b rdy=%b err=%b rx=%0d ec=%0d want all 0", o_v, o_rdy, error, received, err_count);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        n_acc = 0;
        bad_mask = '0;
        got_q.delete();
        en = 1'b1;
        h_rdy = 1'b1;
        run_stream(1, 20, to);
        checks++;
        if (to || got_q.size() !== 1 || error !== 1'b0 || received !== 1) begin
            errors++;
            $display("FAIL ar_restart got to=%b n=%0d err=%b rx=%0d want 0 1 0 1", to, got_q.size(), error, received);
        end
        checks++;
        if (got_q.size() == 1 && got_q[0] !== pat(0)) begin
            errors++;
            $display("FAIL ar_data got %h want %h", got_q[0], pat(0));
        end
    endtask

    task automatic test_saturate();
        bit to;
        apply_reset();
        en = 1'b1;
        h_rdy = 1'b1;
        bad_mask[1] = 1'b1;
        run_stream(2, 20, to);
        checks++;
        if (to || err_count !== 16'd1 || first_err !== 32'd1) begin
            errors++;
            $display("FAIL sat_setup got to=%b ec=%0d fe=%0d want 0 1 1", to, err_count, first_err);
        end
        force dut.err_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_q;
        @(negedge clk);
        bad_mask[3] = 1'b1;
        bad_mask[4] = 1'b1;
        bad_mask[5] = 1'b1;
        run_stream(7, 40, to);
        checks++;
        if (to || err_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got to=%b ec=%h want 0 ffff", to, err_count);
        end
        checks++;
        if (first_err !== 32'd1 || error !== 1'b1) begin
            errors++;
            $display("FAIL sat_first got fe=%0d err=%b want 1 1", first_err, error);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_drain();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsg_ral_link_sdr_echo_node.md
Name: bsg_ral_link_sdr_echo_node

Overview:
Responder end of the SDR corner ready/and link test path. It accepts flits from a link test master, checks each flit against a locally generated expected pattern, buffers it, and echoes it back unchanged. It replaces the trivial combinational loopback, so the round trip has real back-pressure, buffering and per-flit checking. It sits behind a bsg_noc_repeater_node at the far end of the SDR link.

Parameters:
flit_width_p, "inv", flit/data width; must be a multiple of channel_width_p
channel_width_p, 8, checked lane width
els_p, 4, echo FIFO depth, >=2
num_channels_lp, flit_width_p/channel_width_p, derived localparam
link_sif_width_lp, `bsg_ready_and_link_sif_width(flit_width_p), derived localparam

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset (one clock domain; asynchronous assert)
en_i  in  1  run enable
link_sif_i  in  link_sif_width_lp  ready/and link from master (v, data, ready_and_rev)
link_sif_o  out  link_sif_width_lp  ready/and link to master
busy_o  out  1  state != IDLE
error_o  out  1  sticky mismatch flag
err_count_o  out  16  mismatching flits, saturating
first_err_idx_o  out  32  received index of first mismatch
received_o  out  32  flits accepted, wraps
echoed_o  out  32  flits sent back, wraps

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=IDLE; FIFO empty; all counters 0; error_o=0; first_err_idx_o=0; link_sif_o.v=0; link_sif_o.ready_and_rev=0.
- FSM:
  - IDLE -> RUN when en_i=1.
  - RUN -> DRAIN when en_i=0.
  - DRAIN -> IDLE when the FIFO is empty. en_i is ignored in DRAIN.
- Accept: link_sif_o.ready_and_rev = (state==RUN) & en_i & ~fifo_full. This is registered-state based plus en_i; there is no path from link_sif_i.
- A flit is accepted when link_sif_i.v & link_sif_o.ready_and_rev. Data offered while not ready is ignored and never checked.
- Expected pattern for received index n: channel c = (n + c) mod 2^channel_width_p. n = received_o before the increment.
- Check on each accepted flit: on mismatch, error_o<=1 (sticky until reset), err_count_o increments and saturates at 16'hFFFF, and first_err_idx_o captures n only while err_count_o==0.
- Echo FIFO: registered. An accepted flit is visible on link_sif_o.v/data no earlier than the next cycle.
- link_sif_o.v = ~fifo_empty. The head dequeues when link_sif_o.v & link_sif_i.ready_and_rev.
- Data is echoed unchanged and in order, including mismatching flits.
- Simultaneous enqueue and dequeue is legal when not full. When full, ready is 0 that cycle, with no bypass and no combinational full-to-ready via dequeue.
- received_o and echoed_o wrap at 2^32. Invariant: received_o - echoed_o equals FIFO occupancy, at most els_p.
- Reset asserted mid-transfer discards FIFO contents; link outputs drop to 0 asynchronously.

Decomposition:
- Package bsg_ral_sdr_test_pkg:
  - state enum {eIdle, eRun, eDrain}.
  - Counter width constants (32, 16).
  - The link struct via `declare_bsg_ready_and_link_sif_s.
- Sub-module bsg_ral_sdr_pattern_gen (channel_width_p, num_channels_p, clk_i, reset_n_i, yumi_i, o): produces the expected flit and advances on yumi_i.
- The FIFO is an existing bsg_fifo_1r1w_small with a ready/valid wrapper; reset is async active-low and mapped locally.

Test Plan:
- Reset, then en_i=1, master sends 8 flits back-to-back, flit_width_p=32, host ready=1 -> echoed data 32'h03020100, 32'h04030201 … in order, first echo 1 cycle after first accept; received_o=echoed_o=8, error_o=0.
- Host ready_and_rev held 0, els_p=4, master streams -> exactly 4 accepted, ready_and_rev=0 from the 5th; release ready -> 4 echoed, streaming resumes with no loss or duplication.
- Flit 5 corrupted (byte0 xor 8'h01) among 10 -> error_o=1 from the cycle after acceptance, err_count_o=1, first_err_idx_o=5, corrupted flit still echoed verbatim.
- en_i dropped with 3 flits buffered -> ready=0 same cycle, busy_o=1 until the 3 drain, then IDLE; en_i pulse during DRAIN has no effect.
- Assert reset_n_i mid-stream with FIFO half full -> link_sif_o.v, ready, counters and error_o go to 0 without a clock edge; after release, pattern restarts at index 0.
- Force err_count_o to 16'hFFFE, inject 3 errors -> holds 16'hFFFF; first_err_idx_o unchanged.
